// File: rtl/decode_core_arbiter.sv
// Round-robin arbiter/sequencer sharing one external combinational decode core
// among NREQ requesters; responses return over a valid/ready channel tagged with the requester id.
module decode_core_arbiter #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 41,
    parameter int OUT_W = 21,
    parameter int IDW   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*IN_W-1:0]   req_data,
    output logic [IN_W-1:0]        core_in,
    input  logic [OUT_W-1:0]       core_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [OUT_W-1:0]       rsp_data,
    output logic [IDW-1:0]         rsp_id,
    output logic                   busy,
    output logic [15:0]            txn_count
);

    localparam int VEXT_W = 2 ** IDW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDW-1:0]      r_last_grant;
    logic [IDW-1:0]      r_cur_id;
    logic [IN_W-1:0]     r_core_in;
    logic [OUT_W-1:0]    r_rsp_data;
    logic [IDW-1:0]      r_rsp_id;
    logic                r_rsp_valid;
    logic [15:0]         r_txn_count;

    logic [VEXT_W-1:0]   w_valid_ext;
    logic [IDW:0]        w_cand_sum;
    logic [IDW-1:0]      w_grant_idx;
    logic                w_grant_any;
    logic [IN_W-1:0]     w_sel_data;
    logic [NREQ-1:0]     w_req_ready;
    logic                w_accept;
    logic                w_eval_done;
    logic                w_rsp_done;

    // Zero-extend so any IDW-bit candidate index stays inside the vector.
    assign w_valid_ext = VEXT_W'(req_valid);

    // First valid requester searching upward from last_grant+1, wrapping at NREQ.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_cand_sum  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand_sum = {1'b0, r_last_grant} + (IDW+1)'(k);
            if (w_cand_sum >= (IDW+1)'(NREQ)) begin
                w_cand_sum = w_cand_sum - (IDW+1)'(NREQ);
            end
            if (!w_grant_any && w_valid_ext[w_cand_sum[IDW-1:0]]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_cand_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_eval_done = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_any && !rst) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                w_eval_done = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_sel_data  = '0;
        w_req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_idx == IDW'(i)) begin
                w_sel_data     = req_data[i*IN_W +: IN_W];
                w_req_ready[i] = w_accept;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= IDW'(NREQ - 1);
            r_cur_id     <= '0;
            r_core_in    <= '0;
            r_rsp_data   <= '0;
            r_rsp_id     <= '0;
            r_rsp_valid  <= 1'b0;
            r_txn_count  <= '0;
        end else begin
            if (w_accept) begin
                r_core_in    <= w_sel_data;
                r_last_grant <= w_grant_idx;
                r_cur_id     <= w_grant_idx;
            end
            if (w_eval_done) begin
                r_rsp_data  <= core_out;
                r_rsp_id    <= r_cur_id;
                r_rsp_valid <= 1'b1;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
                if (r_txn_count != 16'hFFFF) begin
                    r_txn_count <= r_txn_count + 16'd1;
                end
            end
        end
    end

    assign req_ready = w_req_ready;
    assign core_in   = r_core_in;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != ST_IDLE);
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_decode_core_arbiter.sv
// Self-checking bench for decode_core_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of round-robin grant, latency and counting rules.
module tb_decode_core_arbiter;

    localparam int NREQ  = 4;
    localparam int IN_W  = 41;
    localparam int OUT_W = 21;
    localparam int IDW   = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*IN_W-1:0] req_data;
    logic [IN_W-1:0]      core_in;
    logic [OUT_W-1:0]     core_out;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [OUT_W-1:0]     rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic                 busy;
    logic [15:0]          txn_count;

    int n_cmp = 0;
    int n_bad = 0;
    int ref_last;
    int ref_count;
    logic [IN_W-1:0] rdata [NREQ];

    decode_core_arbiter #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .core_in(core_in), .core_out(core_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    // Stand-in for the external decode core.
    function automatic logic [OUT_W-1:0] decode_fn(input logic [IN_W-1:0] x);
        return (x[20:0] ^ {x[40:21], x[40]}) + 21'd1234;
    endfunction

    assign core_out = decode_fn(core_in);

    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs(input logic [NREQ-1:0] v);
        req_valid = v;
        for (int i = 0; i < NREQ; i++) req_data[i*IN_W +: IN_W] = rdata[i];
    endtask

    task automatic randomize_data();
        for (int i = 0; i < NREQ; i++) rdata[i] = IN_W'({$urandom(), $urandom()});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = 1'b1;
        randomize_data();
        drive_reqs('1);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (txn_count !== 16'h0) begin n_bad++; $display("FAIL reset_txn_count: got %h want 0", txn_count); end
        n_cmp++; if (core_in !== '0) begin n_bad++; $display("FAIL reset_core_in: got %h want 0", core_in); end
        n_cmp++; if (rsp_data !== '0) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        n_cmp++; if (rsp_id !== '0) begin n_bad++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        drive_reqs('0);
        rst = 1'b0;
        ref_last  = NREQ - 1;
        ref_count = 0;
    endtask

    task automatic test_single();
        rdata[2] = 41'h1_2345_6789A;
        drive_reqs(4'b0100);
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        tick();
        drive_reqs('0);
        n_cmp++; if (core_in !== 41'h1_2345_6789A) begin n_bad++; $display("FAIL single_core_in: got %h want 12345_6789a", core_in); end
        n_cmp++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_eval: got busy=%b rsp_valid=%b want 1/0", busy, rsp_valid); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_data !== decode_fn(41'h1_2345_6789A)) begin n_bad++; $display("FAIL single_rsp_data: got %h want %h", rsp_data, decode_fn(41'h1_2345_6789A)); end
        n_cmp++; if (rsp_id !== 3'd2) begin n_bad++; $display("FAIL single_rsp_id: got %0d want 2", rsp_id); end
        tick();
        ref_last = 2;
        ref_count++;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_done: got rsp_valid=%b busy=%b want 0/0", rsp_valid, busy); end
        n_cmp++; if (txn_count !== 16'(ref_count)) begin n_bad++; $display("FAIL single_txn_count: got %0d want %0d", txn_count, ref_count); end
    endtask

    task automatic test_round_robin();
        logic [IN_W-1:0] exp_in;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ref_last  = NREQ - 1;
        ref_count = 0;
        rsp_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            int exp_g;
            exp_g = t % NREQ;
            randomize_data();
            drive_reqs('1);
            #1;
            n_cmp++; if (req_ready !== onehot(exp_g)) begin n_bad++; $display("FAIL rr_grant%0d: got %b want %b", t, req_ready, onehot(exp_g)); end
            exp_in = rdata[exp_g];
            tick();
            n_cmp++; if (req_ready !== '0 || core_in !== exp_in) begin n_bad++; $display("FAIL rr_eval%0d: got ready=%b core_in=%h want 0/%h", t, req_ready, core_in, exp_in); end
            tick();
            n_cmp++; if (rsp_id !== IDW'(exp_g) || rsp_data !== decode_fn(exp_in)) begin n_bad++; $display("FAIL rr_rsp%0d: got id=%0d data=%h want %0d/%h", t, rsp_id, rsp_data, exp_g, decode_fn(exp_in)); end
            tick();
            ref_last = exp_g;
            ref_count++;
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rr_idle%0d: got busy=%b want 0", t, busy); end
        end
        drive_reqs('0);
        n_cmp++; if (txn_count !== 16'(ref_count)) begin n_bad++; $display("FAIL rr_txn_count: got %0d want %0d", txn_count, ref_count); end
    endtask

    task automatic test_backpressure();
        logic [NREQ-1:0] v;
        logic [IN_W-1:0] exp_in;
        int g;
        randomize_data();
        v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        g = pick(v, ref_last);
        rsp_ready = 1'b0;
        drive_reqs(v);
        #1;
        n_cmp++; if (req_ready !== onehot(g)) begin n_bad++; $display("FAIL bp_grant: got %b want %b", req_ready, onehot(g)); end
        exp_in = rdata[g];
        tick();
        ref_last = g;
        randomize_data();
        drive_reqs('1);
        tick();
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== decode_fn(exp_in) || rsp_id !== IDW'(g) || req_ready !== '0 || core_in !== exp_in) begin
                n_bad++;
                $display("FAIL bp_hold%0d: got v=%b d=%h id=%0d rdy=%b in=%h want 1/%h/%0d/0/%h", c, rsp_valid, rsp_data, rsp_id, req_ready, core_in, decode_fn(exp_in), g, exp_in);
            end
            randomize_data();
            drive_reqs(NREQ'($urandom_range(0, (1 << NREQ) - 1)));
            tick();
        end
        n_cmp++; if (txn_count !== 16'(ref_count) || busy !== 1'b1) begin n_bad++; $display("FAIL bp_stall: got count=%0d busy=%b want %0d/1", txn_count, busy, ref_count); end
        drive_reqs('0);
        rsp_ready = 1'b1;
        tick();
        ref_count++;
        n_cmp++; if (rsp_valid !== 1'b0 || txn_count !== 16'(ref_count)) begin n_bad++; $display("FAIL bp_release: got v=%b count=%0d want 0/%0d", rsp_valid, txn_count, ref_count); end
    endtask

    task automatic test_withdrawn();
        randomize_data();
        rsp_ready = 1'b1;
        drive_reqs(4'b0001);
        tick();
        drive_reqs(4'b0010);
        #1;
        n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL wd_eval_ready: got %b want 0", req_ready); end
        tick();
        drive_reqs(4'b1000);
        #1;
        n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL wd_resp_ready: got %b want 0", req_ready); end
        tick();
        ref_count++;
        n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL wd_grant: got %b want 1000", req_ready); end
        tick();
        drive_reqs('0);
        tick();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd3 || rsp_data !== decode_fn(rdata[3])) begin n_bad++; $display("FAIL wd_rsp: got v=%b id=%0d d=%h want 1/3/%h", rsp_valid, rsp_id, rsp_data, decode_fn(rdata[3])); end
        tick();
        ref_count++;
        ref_last = 3;
    endtask

    task automatic test_reset_mid();
        randomize_data();
        rsp_ready = 1'b1;
        drive_reqs(4'b0100);
        tick();
        drive_reqs('0);
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || txn_count !== 16'h0 || core_in !== '0) begin n_bad++; $display("FAIL rstmid_async: got busy=%b v=%b count=%0d in=%h want 0/0/0/0", busy, rsp_valid, txn_count, core_in); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_held: got v=%b want 0", rsp_valid); end
        drive_reqs('1);
        rst = 1'b0;
        ref_last  = NREQ - 1;
        ref_count = 0;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rstmid_priority: got %b want 0001", req_ready); end
        tick();
        drive_reqs('0);
        tick();
        n_cmp++; if (rsp_id !== 3'd0 || rsp_data !== decode_fn(rdata[0])) begin n_bad++; $display("FAIL rstmid_rsp: got id=%0d d=%h want 0/%h", rsp_id, rsp_data, decode_fn(rdata[0])); end
        tick();
        ref_count++;
        ref_last = 0;
        n_cmp++; if (txn_count !== 16'(ref_count)) begin n_bad++; $display("FAIL rstmid_count: got %0d want %0d", txn_count, ref_count); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [NREQ-1:0] v;
            logic [IN_W-1:0] exp_in;
            int g;
            int bp;
            randomize_data();
            v = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            drive_reqs(v);
            rsp_ready = 1'($urandom_range(0, 1));
            #1;
            g = pick(v, ref_last);
            n_cmp++; if (req_ready !== onehot(g)) begin n_bad++; $display("FAIL rnd_grant%0d: got %b want %b", n, req_ready, onehot(g)); end
            tick();
            if (g < 0) begin
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rnd_idle%0d: got busy=%b want 0", n, busy); end
                continue;
            end
            exp_in = rdata[g];
            ref_last = g;
            n_cmp++; if (core_in !== exp_in || busy !== 1'b1) begin n_bad++; $display("FAIL rnd_eval%0d: got in=%h busy=%b want %h/1", n, core_in, busy, exp_in); end
            randomize_data();
            drive_reqs(NREQ'($urandom_range(0, (1 << NREQ) - 1)));
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
            bp = $urandom_range(0, 3);
            rsp_ready = 1'b0;
            for (int c = 0; c <= bp; c++) begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_data !== decode_fn(exp_in) || rsp_id !== IDW'(g) || req_ready !== '0) begin
                    n_bad++;
                    $display("FAIL rnd_rsp%0d: got v=%b d=%h id=%0d rdy=%b want 1/%h/%0d/0", n, rsp_valid, rsp_data, rsp_id, req_ready, decode_fn(exp_in), g);
                end
                if (c < bp) begin
                    drive_reqs(NREQ'($urandom_range(0, (1 << NREQ) - 1)));
                    tick();
                end
            end
            drive_reqs('0);
            rsp_ready = 1'b1;
            tick();
            ref_count++;
            n_cmp++; if (rsp_valid !== 1'b0 || txn_count !== 16'(ref_count)) begin n_bad++; $display("FAIL rnd_done%0d: got v=%b count=%0d want 0/%0d", n, rsp_valid, txn_count, ref_count); end
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        force dut.r_txn_count = 16'hFFFE;
        #1;
        release dut.r_txn_count;
        #1;
        exp_cnt = 16'hFFFE;
        n_cmp++; if (txn_count !== 16'hFFFE) begin n_bad++; $display("FAIL sat_preload: got %h want fffe", txn_count); end
        rsp_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            randomize_data();
            drive_reqs(4'b0001);
            tick();
            drive_reqs('0);
            tick();
            tick();
            exp_cnt = (exp_cnt < 16'hFFFF) ? exp_cnt + 1 : exp_cnt;
            n_cmp++; if (txn_count !== 16'(exp_cnt)) begin n_bad++; $display("FAIL sat_count%0d: got %h want %h", t, txn_count, 16'(exp_cnt)); end
        end
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        rst       = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_withdrawn();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
